// File: rtl/pdp8lmemreq_pkg.sv
// Shared types for the PDP-8/L memory-cycle initiator: op codes, FSM states,
// timeout default and the read-modify-write data selection.
package pdp8lmemreq_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 200;
    localparam int          CNT_W           = 16;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_INCR  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAITRD,
        S_MODIFY,
        S_WAITWR,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [11:0] data;
        logic        ovf;
    } wb_t;

    // Word to restore in the write-back phase; the reserved op behaves as a read.
    function automatic wb_t modify_word(op_e op, logic [11:0] rdat, logic [11:0] wdat);
        wb_t r;
        r.ovf = 1'b0;
        case (op)
            OP_WRITE: r.data = wdat;
            OP_INCR: begin
                r.data = rdat + 12'd1;
                r.ovf  = (rdat == 12'o7777);
            end
            default:  r.data = rdat;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pdp8lmemreq_if.sv
// Request channel (on-chip master side) and PDP-8/L external memory bus.
// The initiator is the slave of the request channel and the master of the memory bus.
interface pdp8lmemreq_req_if;
    logic        reqvalid;
    logic        reqready;
    logic [1:0]  reqop;
    logic [14:0] reqaddr;
    logic [11:0] reqwdat;
    logic        rspvalid;
    logic        rspready;
    logic [11:0] rsprdat;
    logic        rspovf;
    logic        rsptimeout;

    modport master (
        output reqvalid, reqop, reqaddr, reqwdat, rspready,
        input  reqready, rspvalid, rsprdat, rspovf, rsptimeout
    );
    modport slave (
        input  reqvalid, reqop, reqaddr, reqwdat, rspready,
        output reqready, rspvalid, rsprdat, rspovf, rsptimeout
    );
endinterface

interface pdp8lmemreq_mem_if;
    logic        memstart;
    logic        memwrite;
    logic [11:0] memaddr;
    logic [11:0] memwdat;
    logic [11:0] memrdat;
    logic        _mrdone;
    logic        _mwdone;
    logic [2:0]  brkfld;
    logic        _bf_enab;

    modport master (
        output memstart, memwrite, memaddr, memwdat, brkfld, _bf_enab,
        input  memrdat, _mrdone, _mwdone
    );
    modport slave (
        input  memstart, memwrite, memaddr, memwdat, brkfld, _bf_enab,
        output memrdat, _mrdone, _mwdone
    );
endinterface

// File: rtl/pdp8lmemreq_edge.sv
// Conditioner for one active-low done line: strobe on the first low sample
// after the line was high, plus a flag that the line is currently high.
module pdp8lmemreq_edge (
    input  logic CLOCK,
    input  logic _RESET,
    input  logic done_n_i,
    output logic fall_o,
    output logic high_o
);

    logic prev_q;

    // NOTE: clocked state is written with non-blocking assignments only.
    always_ff @(posedge CLOCK or negedge _RESET) begin
        if (!_RESET) prev_q <= 1'b1;
        else         prev_q <= done_n_i;
    end

    assign fall_o = prev_q & ~done_n_i;
    assign high_o = done_n_i;

endmodule

// File: rtl/pdp8lmemreq.sv
// PDP-8/L break-cycle initiator: one read + write-back core cycle per request.
// Optional PDP8L_MEMREQ_STATS_EN adds saturating completed/aborted cycle counters.
module pdp8lmemreq
    import pdp8lmemreq_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              _RESET,
    pdp8lmemreq_req_if.slave  req,
    pdp8lmemreq_mem_if.master mem
`ifdef PDP8L_MEMREQ_STATS_EN
    ,
    output logic [15:0]       statcycles,
    output logic [7:0]        stattimeouts
`endif
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    op_e              op_q;
    logic [11:0]      wdat_q;
    logic [11:0]      memaddr_q;
    logic [2:0]       brkfld_q;
    logic [11:0]      memwdat_q;
    logic [11:0]      rsprdat_q;
    logic             rspovf_q;
    logic             rsptimeout_q;
    logic             memstart_q;
    logic             memwrite_q;
    logic             bf_enab_n_q;
    logic             reqready_q;
    logic             rspvalid_q;
    logic [CNT_W-1:0] cnt_q;

    logic mr_fall, mr_high, mw_fall, mw_high;
    wb_t  wb_d;

    pdp8lmemreq_edge u_mrdone (
        .CLOCK    (CLOCK),
        ._RESET   (_RESET),
        .done_n_i (mem._mrdone),
        .fall_o   (mr_fall),
        .high_o   (mr_high)
    );

    pdp8lmemreq_edge u_mwdone (
        .CLOCK    (CLOCK),
        ._RESET   (_RESET),
        .done_n_i (mem._mwdone),
        .fall_o   (mw_fall),
        .high_o   (mw_high)
    );

    always_comb wb_d = modify_word(op_q, mem.memrdat, wdat_q);

    // NOTE: every output register has a reset value so a mid-cycle reset idles the bus at once.
    always_ff @(posedge CLOCK or negedge _RESET) begin
        if (!_RESET) begin
            state_q      <= S_IDLE;
            op_q         <= OP_READ;
            wdat_q       <= '0;
            memaddr_q    <= '0;
            brkfld_q     <= '0;
            memwdat_q    <= '0;
            rsprdat_q    <= '0;
            rspovf_q     <= 1'b0;
            rsptimeout_q <= 1'b0;
            memstart_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            bf_enab_n_q  <= 1'b1;
            reqready_q   <= 1'b1;
            rspvalid_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req.reqvalid) begin
                    op_q         <= op_e'(req.reqop);
                    wdat_q       <= req.reqwdat;
                    memaddr_q    <= req.reqaddr[11:0];
                    brkfld_q     <= req.reqaddr[14:12];
                    bf_enab_n_q  <= 1'b0;
                    memstart_q   <= 1'b1;
                    reqready_q   <= 1'b0;
                    rspovf_q     <= 1'b0;
                    rsptimeout_q <= 1'b0;
                    state_q      <= S_START;
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAITRD;
                end
                S_WAITRD: begin
                    if (mr_fall) begin
                        rsprdat_q  <= mem.memrdat;
                        memwdat_q  <= wb_d.data;
                        rspovf_q   <= wb_d.ovf;
                        memstart_q <= 1'b0;
                        state_q    <= S_MODIFY;
                    end else if (cnt_q == LIMIT) begin
                        memstart_q   <= 1'b0;
                        bf_enab_n_q  <= 1'b1;
                        rsptimeout_q <= 1'b1;
                        rsprdat_q    <= '0;
                        rspvalid_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Write phase starts only once both done lines are idle high.
                S_MODIFY: if (mr_high && mw_high) begin
                    memwrite_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= S_WAITWR;
                end
                S_WAITWR: begin
                    if (mw_fall) begin
                        memwrite_q  <= 1'b0;
                        bf_enab_n_q <= 1'b1;
                        rspvalid_q  <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == LIMIT) begin
                        memwrite_q   <= 1'b0;
                        bf_enab_n_q  <= 1'b1;
                        rsptimeout_q <= 1'b1;
                        rspvalid_q   <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: if (req.rspready) begin
                    rspvalid_q <= 1'b0;
                    reqready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req.reqready   = reqready_q;
    assign req.rspvalid   = rspvalid_q;
    assign req.rsprdat    = rsprdat_q;
    assign req.rspovf     = rspovf_q;
    assign req.rsptimeout = rsptimeout_q;
    assign mem.memstart   = memstart_q;
    assign mem.memwrite   = memwrite_q;
    assign mem.memaddr    = memaddr_q;
    assign mem.memwdat    = memwdat_q;
    assign mem.brkfld     = brkfld_q;
    assign mem._bf_enab   = bf_enab_n_q;

`ifdef PDP8L_MEMREQ_STATS_EN
    logic [15:0] statcycles_q;
    logic [7:0]  stattimeouts_q;
    logic        done_ev, abort_ev;

    assign done_ev  = (state_q == S_WAITWR) && mw_fall;
    assign abort_ev = (cnt_q == LIMIT) &&
                      (((state_q == S_WAITRD) && !mr_fall) ||
                       ((state_q == S_WAITWR) && !mw_fall));

    always_ff @(posedge CLOCK or negedge _RESET) begin
        if (!_RESET) begin
            statcycles_q   <= '0;
            stattimeouts_q <= '0;
        end else begin
            if (done_ev && (statcycles_q != '1))    statcycles_q   <= statcycles_q + 16'd1;
            if (abort_ev && (stattimeouts_q != '1)) stattimeouts_q <= stattimeouts_q + 8'd1;
        end
    end

    assign statcycles   = statcycles_q;
    assign stattimeouts = stattimeouts_q;
`endif

endmodule

// File: tb/tb_pdp8lmemreq.sv
// Scoreboard bench for pdp8lmemreq: responder model on the memory bus, a shadow
// memory reference model, and a response monitor decoupled from stimulus.
module tb_pdp8lmemreq;
    import pdp8lmemreq_pkg::*;

    localparam int unsigned TMO = TIMEOUT_DEFAULT;

    logic CLOCK = 1'b0;
    logic _RESET;
    always #5 CLOCK = ~CLOCK;

    pdp8lmemreq_req_if req_bus ();
    pdp8lmemreq_mem_if mem_bus ();

`ifdef PDP8L_MEMREQ_STATS_EN
    logic [15:0] statcycles;
    logic [7:0]  stattimeouts;
`endif

    pdp8lmemreq #(.TIMEOUT(TMO)) dut (
        .CLOCK  (CLOCK),
        ._RESET (_RESET),
        .req    (req_bus),
        .mem    (mem_bus)
`ifdef PDP8L_MEMREQ_STATS_EN
        ,
        .statcycles   (statcycles),
        .stattimeouts (stattimeouts)
`endif
    );

    typedef struct {
        logic [11:0] rdat;
        logic        ovf;
        logic        tmo;
        logic [14:0] addr;
        logic [11:0] wb;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] core   [0:32767];
    logic [11:0] shadow [0:32767];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        hold_rd = 1'b0;
    logic        rand_rdy = 1'b0;
    int          rst_count = 0;
    int          wb_count = 0;
    logic [14:0] wb_addr;
    logic [11:0] wb_data;
    int          ms_total = 0;
    int          ms_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'o%0o, want 'o%0o", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: expected event did not occur within its bound", name);
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] v);
        core[a]   = v;
        shadow[a] = v;
    endtask

    // Reference model: what one request must return and write back.
    task automatic model_push(input logic [1:0] op, input logic [14:0] a,
                              input logic [11:0] wd, input logic tmo);
        exp_t        e;
        logic [11:0] rd;
        rd     = shadow[a];
        e.addr = a;
        e.tmo  = tmo;
        e.ovf  = 1'b0;
        if (tmo) begin
            e.rdat = '0;
            e.wb   = '0;
        end else begin
            e.rdat = rd;
            if (op == 2'd1) e.wb = wd;
            else if (op == 2'd2) begin
                e.wb  = 12'((int'(rd) + 1) % 4096);
                e.ovf = (int'(rd) == 4095);
            end else e.wb = rd;
            shadow[a] = e.wb;
        end
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [14:0] a,
                         input logic [11:0] wd, input logic tmo);
        int k = 0;
        @(negedge CLOCK);
        req_bus.reqvalid = 1'b1;
        req_bus.reqop    = op;
        req_bus.reqaddr  = a;
        req_bus.reqwdat  = wd;
        while (!req_bus.reqready && k < 2000) begin
            @(negedge CLOCK);
            k++;
        end
        if (!req_bus.reqready) begin
            fail_now("accept");
            req_bus.reqvalid = 1'b0;
            return;
        end
        model_push(op, a, wd, tmo);
        @(negedge CLOCK);
        req_bus.reqvalid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int k = 0;
        while (!req_bus.rspvalid && k < 1000) begin
            @(negedge CLOCK);
            k++;
        end
        if (!req_bus.rspvalid) fail_now(name);
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || !req_bus.reqready) && k < 3000) begin
            @(negedge CLOCK);
            k++;
        end
        if (k >= 3000) fail_now("drain");
    endtask

    always @(negedge _RESET) rst_count++;

    // Responder: _mrdone low 50 cycles after memstart for 10 cycles, _mwdone 5 cycles after memwrite.
    initial begin : responder
        logic [14:0] a;
        int          k;
        int          rst0;
        mem_bus._mrdone = 1'b1;
        mem_bus._mwdone = 1'b1;
        mem_bus.memrdat = '0;
        forever begin
            @(negedge CLOCK);
            if (_RESET && mem_bus.memstart) begin
                rst0 = rst_count;
                a    = {mem_bus.brkfld, mem_bus.memaddr};
                if (hold_rd) begin
                    k = 0;
                    while (mem_bus.memstart && k < 1000) begin
                        @(negedge CLOCK);
                        k++;
                    end
                end else begin
                    repeat (50) @(negedge CLOCK);
                    mem_bus.memrdat = core[a];
                    mem_bus._mrdone = 1'b0;
                    repeat (10) @(negedge CLOCK);
                    mem_bus._mrdone = 1'b1;
                    k = 0;
                    while (!mem_bus.memwrite && rst_count == rst0 && k < 100) begin
                        @(negedge CLOCK);
                        k++;
                    end
                    if (mem_bus.memwrite && rst_count == rst0) begin
                        repeat (5) @(negedge CLOCK);
                        if (rst_count == rst0) begin
                            core[a]         = mem_bus.memwdat;
                            wb_addr         = {mem_bus.brkfld, mem_bus.memaddr};
                            wb_data         = mem_bus.memwdat;
                            wb_count++;
                            mem_bus._mwdone = 1'b0;
                            repeat (2) @(negedge CLOCK);
                            mem_bus._mwdone = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : ms_mon
        logic prev = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (mem_bus.memstart) ms_total++;
            if (mem_bus.memstart && !prev) ms_rises++;
            prev = mem_bus.memstart;
        end
    end

    initial begin : rdy_drv
        forever begin
            @(negedge CLOCK);
            if (rand_rdy) req_bus.rspready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each presented response against the head of the scoreboard.
    initial begin : monitor
        exp_t e;
        logic shown = 1'b0;
        int   wb_last = 0;
        forever begin
            @(negedge CLOCK);
            if (!_RESET) shown = 1'b0;
            else if (req_bus.rspvalid && !shown) begin
                shown = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got a response, want none");
                end else begin
                    e = sb.pop_front();
                    check("rsprdat", req_bus.rsprdat, e.rdat);
                    check("rspovf", req_bus.rspovf, e.ovf);
                    check("rsptimeout", req_bus.rsptimeout, e.tmo);
                    check("writeback_count", wb_count - wb_last, e.tmo ? 0 : 1);
                    if (!e.tmo) begin
                        check("wb_addr", wb_addr, e.addr);
                        check("wb_data", wb_data, e.wb);
                    end
                    wb_last = wb_count;
                end
            end else if (!req_bus.rspvalid) shown = 1'b0;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [14:0] pool [8];
        int          t0, bad, k;
        _RESET           = 1'b0;
        req_bus.reqvalid = 1'b0;
        req_bus.reqop    = '0;
        req_bus.reqaddr  = '0;
        req_bus.reqwdat  = '0;
        req_bus.rspready = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            core[i]   = 12'($urandom);
            shadow[i] = core[i];
        end
        preload(15'o12345, 12'o7070);
        preload(15'o00100, 12'o0055);
        preload(15'o20007, 12'o7777);
        preload(15'o30010, 12'o0005);
        preload(15'o71234, 12'o7776);
        pool[0] = 15'o12345; pool[1] = 15'o00100; pool[2] = 15'o20007; pool[3] = 15'o30010;
        pool[4] = 15'o71234; pool[5] = 15'o77777; pool[6] = 15'o00000; pool[7] = 15'o40404;

        repeat (3) @(negedge CLOCK);
        check("rst_reqready", req_bus.reqready, 1);
        check("rst_rspvalid", req_bus.rspvalid, 0);
        check("rst_memstart", mem_bus.memstart, 0);
        check("rst_memwrite", mem_bus.memwrite, 0);
        check("rst_bf_enab", mem_bus._bf_enab, 1);
        check("rst_memaddr", mem_bus.memaddr, 0);
        check("rst_memwdat", mem_bus.memwdat, 0);
        check("rst_brkfld", mem_bus.brkfld, 0);
        check("rst_rsprdat", req_bus.rsprdat, 0);
        check("rst_rspovf", req_bus.rspovf, 0);
        check("rst_rsptimeout", req_bus.rsptimeout, 0);
        _RESET = 1'b1;

        // Directed: read, write, increment with and without wrap.
        issue(2'd0, 15'o12345, 12'o0000, 1'b0);
        issue(2'd1, 15'o00100, 12'o1234, 1'b0);
        issue(2'd2, 15'o20007, 12'o0000, 1'b0);
        issue(2'd2, 15'o30010, 12'o0000, 1'b0);
        drain();

        // Random ops over a small address pool so increments revisit cells.
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            issue(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], 12'($urandom), 1'b0);
        end
        rand_rdy = 1'b0;
        req_bus.rspready = 1'b1;
        drain();

        // Responder never answers the read phase.
        hold_rd = 1'b1;
        t0 = ms_total;
        issue(2'd0, 15'o04321, 12'o0000, 1'b1);
        wait_rsp("tmo_rspvalid");
        check("tmo_memstart", mem_bus.memstart, 0);
        check("tmo_bf_enab", mem_bus._bf_enab, 1);
        check("tmo_memstart_cycles", ms_total - t0, TMO + 1);
        drain();
        hold_rd = 1'b0;

        // Reset during the write-back phase.
        issue(2'd0, 15'o05555, 12'o0000, 1'b0);
        k = 0;
        while (!mem_bus.memwrite && k < 500) begin
            @(negedge CLOCK);
            k++;
        end
        if (!mem_bus.memwrite) fail_now("reset_reach_waitwr");
        repeat (2) @(negedge CLOCK);
        #2 _RESET = 1'b0;
        #1;
        check("rstmid_memwrite", mem_bus.memwrite, 0);
        check("rstmid_memstart", mem_bus.memstart, 0);
        check("rstmid_bf_enab", mem_bus._bf_enab, 1);
        check("rstmid_rspvalid", req_bus.rspvalid, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge CLOCK);
        _RESET = 1'b1;
        @(negedge CLOCK);
        check("rstmid_reqready", req_bus.reqready, 1);
        issue(2'd2, 15'o05555, 12'o0000, 1'b0);
        drain();

        // Response back-pressure: no second cycle may start while RESP is held.
        req_bus.rspready = 1'b0;
        issue(2'd0, 15'o11111, 12'o0000, 1'b0);
        wait_rsp("bp_rspvalid");
        @(negedge CLOCK);
        req_bus.reqvalid = 1'b1;
        req_bus.reqop    = 2'd0;
        req_bus.reqaddr  = 15'o22222;
        t0  = ms_rises;
        bad = 0;
        repeat (100) begin
            @(negedge CLOCK);
            if (req_bus.reqready) bad++;
        end
        check("bp_reqready_low_cycles", bad, 0);
        check("bp_memstart_rises", ms_rises - t0, 0);
        model_push(2'd0, 15'o22222, 12'o0000, 1'b0);
        req_bus.rspready = 1'b1;
        k = 0;
        while (!mem_bus.memstart && k < 50) begin
            @(negedge CLOCK);
            k++;
        end
        req_bus.reqvalid = 1'b0;
        check("bp_restart_latency", k, 2);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
